// File: rtl/uart_boot_loader.sv
// UART boot loader: frames received bytes into 32-bit little-endian words, writes them
// to instruction memory and holds the core in reset until a checksummed frame has loaded.
module uart_boot_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned MAX_WORDS      = 1024,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd1_000_000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        imem_wr_en,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wr_data,
  output logic        core_reset_n,
  output logic        boot_done,
  output logic        boot_error
);

  typedef enum logic [2:0] {
    IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERROR
  } state_t;

  state_t      state, state_next;
  logic [7:0]  len_lo;
  logic [15:0] len_words;
  logic [1:0]  byte_idx;
  logic [15:0] word_idx;
  logic [23:0] word_reg;
  logic [7:0]  checksum;
  logic [19:0] timeout_cnt;

  logic [15:0] len_rx;
  logic        in_frame;
  logic        timeout_hit;
  logic        last_byte;
  logic        last_word;

  assign len_rx      = {rx_data, len_lo};
  assign in_frame    = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CSUM);
  // A byte arriving in the final cycle wins over the timeout.
  assign timeout_hit = in_frame && !rx_valid && (timeout_cnt == TIMEOUT_CYCLES - 20'd1);
  assign last_byte   = (byte_idx == 2'd3);
  assign last_word   = (word_idx == len_words - 16'd1);

  // NOTE: non-blocking (<=) in clocked blocks so every flop samples pre-edge values.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: state_next gets its default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (rx_valid && rx_data == SYNC_BYTE) state_next = LEN0;
      LEN0:  if (rx_valid) state_next = LEN1;
      LEN1: begin
        if (rx_valid) begin
          if ({16'd0, len_rx} > MAX_WORDS) state_next = ERROR;
          else if (len_rx == 16'd0)        state_next = CSUM;
          else                             state_next = DATA;
        end
      end
      DATA:  if (rx_valid && last_byte && last_word) state_next = CSUM;
      CSUM:  if (rx_valid) state_next = (rx_data == checksum) ? DONE : ERROR;
      DONE:  state_next = DONE;
      ERROR: if (rx_valid && rx_data == SYNC_BYTE) state_next = LEN0;
      default: state_next = IDLE;
    endcase
    if (timeout_hit) state_next = ERROR;
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      imem_wr_en   <= 1'b0;
      imem_addr    <= BASE_ADDR;
      imem_wr_data <= 32'd0;
      core_reset_n <= 1'b0;
      boot_done    <= 1'b0;
      boot_error   <= 1'b0;
      len_lo       <= 8'd0;
      len_words    <= 16'd0;
      byte_idx     <= 2'd0;
      word_idx     <= 16'd0;
      word_reg     <= 24'd0;
      checksum     <= 8'd0;
      timeout_cnt  <= 20'd0;
    end else begin
      imem_wr_en   <= 1'b0;
      boot_done    <= (state_next == DONE);
      core_reset_n <= (state_next == DONE);
      boot_error   <= (state_next == ERROR);

      if (rx_valid || !in_frame || timeout_hit) timeout_cnt <= 20'd0;
      else                                      timeout_cnt <= timeout_cnt + 20'd1;

      if (rx_valid) begin
        case (state)
          LEN0: len_lo <= rx_data;
          LEN1: begin
            len_words <= len_rx;
            checksum  <= 8'd0;
            byte_idx  <= 2'd0;
            word_idx  <= 16'd0;
          end
          DATA: begin
            checksum <= checksum + rx_data;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_reg[7:0]   <= rx_data;
              2'd1: word_reg[15:8]  <= rx_data;
              2'd2: word_reg[23:16] <= rx_data;
              default: begin
                imem_wr_en   <= 1'b1;
                imem_wr_data <= {rx_data, word_reg};
                imem_addr    <= BASE_ADDR + {14'd0, word_idx, 2'b00};
                word_idx     <= word_idx + 16'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Sits upstream of the MCU core and instruction memory.
- Consumes received bytes from the UART receiver, assembles them into 32-bit little-endian instruction words, and writes them into instruction memory.
- Holds the RISC-V core in reset until a complete frame with a valid checksum has been loaded, then releases it.

Parameters:
- BASE_ADDR, 32'h0000_0000, instruction-memory byte address of word 0.
- MAX_WORDS, 1024, largest accepted word count; a larger count is a frame error.
- TIMEOUT_CYCLES, 20'd1_000_000, maximum CLOCK cycles allowed between bytes once a frame has started.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- CLOCK, input, 1, system clock; all logic on the rising edge.
- RESET, input, 1, asynchronous active-low reset.
- rx_data, input, 8, received byte; valid only when rx_valid is high.
- rx_valid, input, 1, one-cycle strobe per received byte.
- imem_wr_en, output, 1, one-cycle instruction-memory write strobe.
- imem_addr, output, 32, byte address for the write: BASE_ADDR + 4*index.
- imem_wr_data, output, 32, assembled instruction word.
- core_reset_n, output, 1, active-low reset to the core; 0 until boot succeeds.
- boot_done, output, 1, level; high once a frame has been loaded with a correct checksum.
- boot_error, output, 1, level; high in the ERROR state.

Behaviour:
- Reset (RESET=0, asynchronous) forces the following, regardless of state or any partial frame:
  - state IDLE;
  - imem_wr_en=0, imem_addr=BASE_ADDR, imem_wr_data=0;
  - core_reset_n=0, boot_done=0, boot_error=0;
  - byte counter, word counter, checksum and timeout counter all 0.
- Frame format, little-endian: SYNC_BYTE, LEN_LO, LEN_HI, then 4*LEN payload bytes (byte 0 = word bits [7:0]), then CSUM.
- CSUM equals the 8-bit wrapping sum of all payload bytes only; the sync and length bytes are excluded.
- State IDLE: a byte equal to SYNC_BYTE goes to LEN0; any other byte is ignored.
- State LEN0: store LEN_LO, go to LEN1.
- State LEN1: form LEN from the two length bytes.
  - LEN > MAX_WORDS goes to ERROR.
  - LEN == 0 goes to CSUM.
  - Otherwise go to DATA, clearing the checksum and byte/word indices.
- State DATA:
  - Each byte shifts into the word register at lane byte_idx and is added into the checksum.
  - On the 4th byte of a word, the registered outputs update on the next edge: imem_wr_en=1 for exactly one cycle, imem_wr_data = the full word, imem_addr = BASE_ADDR + {word_idx,2'b00}. word_idx then increments.
  - Latency is one cycle from the rx_valid of the 4th byte to the imem_wr_en pulse.
  - After word LEN-1 has been written, go to CSUM.
- State CSUM: if the byte equals the accumulated checksum go to DONE, otherwise go to ERROR.
- State DONE:
  - boot_done=1 and core_reset_n=1, both registered; they rise on the edge after the CSUM byte.
  - All further rx bytes are ignored; only RESET leaves DONE.
- State ERROR:
  - boot_error=1 and core_reset_n=0.
  - A SYNC_BYTE clears boot_error and goes to LEN0 (retry); other bytes are ignored.
- Timeout:
  - The counter clears on every rx_valid and runs only in LEN0, LEN1, DATA and CSUM.
  - When it reaches TIMEOUT_CYCLES-1 with no byte arriving, go to ERROR.
  - An rx_valid in that same cycle takes priority; the byte is processed and there is no timeout.
- Sync handling: a SYNC_BYTE value appearing inside a frame is treated as data, never as a resync.
- Write counts: imem_wr_en never asserts outside DATA, and at most LEN pulses occur per frame.
- rx_valid strobes may arrive back-to-back on consecutive cycles; every strobe must be consumed with no loss.
- Width rules:
  - Checksum is 8 bits and wraps modulo 256.
  - word_idx is 16 bits.
  - The address add is 32 bits; wrap above 32'hFFFF_FFFF is not checked.

Test Plan:
- Nominal frame: bytes A5,02,00,13,00,00,00,93,00,10,00,B6.
  - Expect two imem_wr_en pulses: addr 0 / data 32'h0000_0013, then addr 4 / data 32'h0010_0093.
  - Expect boot_done=1 and core_reset_n=1 one cycle after the B6 byte.
- Bad checksum: the same frame with a final byte of B7.
  - Expect boot_error=1 and core_reset_n=0.
  - Then send the correct frame; expect boot_error to clear and boot_done=1.
- Oversize length: A5,01,04 (LEN=1025 > MAX_WORDS) -> ERROR immediately, with zero write pulses.
- Timeout: send A5,01,00,AA and then stall for TIMEOUT_CYCLES cycles -> boot_error=1 and no write pulse.
  - Repeat with the next byte landing exactly on the last cycle; expect no error.
- Edge cases:
  - Junk bytes 00,FF,5A before A5 are ignored.
  - Zero-length frame A5,00,00,00 -> boot_done=1 with no writes.
  - Bytes sent after DONE produce no writes.
- Reset mid-DATA: assert RESET low asynchronously after 6 payload bytes.
  - All outputs must return to reset values immediately.
  - A following complete frame must load correctly from word 0.
